// File: rtl/move_long_sequencer_if.sv
// Command channel of move_long_sequencer: operand handshake plus done/error pulses.
interface move_long_sequencer_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [MemoryElementWidth-1:0] cmd_source_array;
  logic [MemoryElementWidth-1:0] cmd_source_offset;
  logic [MemoryElementWidth-1:0] cmd_target_array;
  logic [MemoryElementWidth-1:0] cmd_target_offset;
  logic [MemoryElementWidth-1:0] cmd_length;
  logic                          done;
  logic                          error;

  modport master (
    output cmd_valid, cmd_source_array, cmd_source_offset,
           cmd_target_array, cmd_target_offset, cmd_length,
    input  cmd_ready, done, error
  );

  modport slave (
    input  cmd_valid, cmd_source_array, cmd_source_offset,
           cmd_target_array, cmd_target_offset, cmd_length,
    output cmd_ready, done, error
  );
endinterface

// File: rtl/move_long_sequencer.sv
// Heap element block-copy engine sharing one heap port with a CPU requester.
// Define MOVE_LONG_OVERLAP_EN to copy descending when an in-array move overlaps forward.
//
// state | meaning
// IDLE  | waiting for a command, CPU owns the heap port
// READ  | engine reads source element k (CPU may win alternate contested slots)
// WRITE | engine writes heap_rdata to target element k
// SIZE  | array length update pulse for the target array
// DONE  | completion pulse
module move_long_sequencer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int NArrays            = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  move_long_sequencer_if.slave          cmd,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [MemoryElementWidth-1:0] cpu_addr,
  input  logic [MemoryElementWidth-1:0] cpu_wdata,
  output logic                          cpu_gnt,
  output logic                          heap_en,
  output logic                          heap_we,
  output logic [MemoryElementWidth-1:0] heap_addr,
  output logic [MemoryElementWidth-1:0] heap_wdata,
  input  logic [MemoryElementWidth-1:0] heap_rdata,
  output logic                          size_we,
  output logic [MemoryElementWidth-1:0] size_array,
  output logic [MemoryElementWidth-1:0] size_value
);
  localparam int W = MemoryElementWidth;

  typedef enum logic [2:0] {IDLE, READ, WRITE, SIZE, DONE} state_t;

  state_t         state;
  logic [W-1:0]   src_base, tgt_base, tgt_arr, tgt_end, k, remaining;
  logic           eng_won_last, cmd_ready_q, done_q, error_q;
  logic [W:0]     src_end, tgt_span_end;
  logic           illegal, descend;

  // Legality is checked one bit wider so a huge offset cannot wrap into range.
  assign src_end      = {1'b0, cmd.cmd_source_offset} + {1'b0, cmd.cmd_length};
  assign tgt_span_end = {1'b0, cmd.cmd_target_offset} + {1'b0, cmd.cmd_length};
  assign illegal = (cmd.cmd_source_array >= W'(NArrays)) ||
                   (cmd.cmd_target_array >= W'(NArrays)) ||
                   (src_end > (W+1)'(NArea)) || (tgt_span_end > (W+1)'(NArea));

`ifdef MOVE_LONG_OVERLAP_EN
  assign descend = (cmd.cmd_source_array == cmd.cmd_target_array) &&
                   (cmd.cmd_source_offset < cmd.cmd_target_offset) &&
                   ({1'b0, cmd.cmd_target_offset} < src_end);
`else
  assign descend = 1'b0;
`endif

  logic dir_down;

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.done      = done_q;
  assign cmd.error     = error_q;

  assign cpu_gnt = reset && cpu_req &&
                   ((state == IDLE) || (state == SIZE) || (state == DONE) ||
                    ((state == READ) && eng_won_last));

  always_comb begin
    heap_en    = 1'b0;
    heap_we    = 1'b0;
    heap_addr  = '0;
    heap_wdata = '0;
    if (cpu_gnt) begin
      heap_en    = 1'b1;
      heap_we    = cpu_we;
      heap_addr  = cpu_addr;
      heap_wdata = cpu_wdata;
    end else if (state == READ) begin
      heap_en   = 1'b1;
      heap_addr = src_base + k;
    end else if (state == WRITE) begin
      heap_en    = 1'b1;
      heap_we    = 1'b1;
      heap_addr  = tgt_base + k;
      heap_wdata = heap_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      k            <= '0;
      remaining    <= '0;
      eng_won_last <= 1'b1;
      dir_down     <= 1'b0;
      src_base     <= '0;
      tgt_base     <= '0;
      tgt_arr      <= '0;
      tgt_end      <= '0;
      cmd_ready_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      size_we      <= 1'b0;
      size_array   <= '0;
      size_value   <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      size_we <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_ready_q && cmd.cmd_valid) begin
            cmd_ready_q  <= 1'b0;
            eng_won_last <= 1'b1;
            if (illegal) begin
              error_q <= 1'b1;
            end else begin
              src_base  <= W'(NArea) * cmd.cmd_source_array + cmd.cmd_source_offset;
              tgt_base  <= W'(NArea) * cmd.cmd_target_array + cmd.cmd_target_offset;
              tgt_arr   <= cmd.cmd_target_array;
              tgt_end   <= cmd.cmd_target_offset + cmd.cmd_length;
              remaining <= cmd.cmd_length;
              dir_down  <= descend;
              k         <= descend ? cmd.cmd_length - W'(1) : '0;
              if (cmd.cmd_length == '0) begin
                state  <= DONE;
                done_q <= 1'b1;
              end else begin
                state <= READ;
              end
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        READ: begin
          // A granted CPU stalls the engine here; history flips on every contest.
          if (cpu_gnt) begin
            eng_won_last <= 1'b0;
          end else begin
            if (cpu_req) eng_won_last <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          remaining <= remaining - W'(1);
          k         <= dir_down ? k - W'(1) : k + W'(1);
          if (remaining == W'(1)) begin
            state      <= SIZE;
            size_we    <= 1'b1;
            size_array <= tgt_arr;
            size_value <= tgt_end;
          end else begin
            state <= READ;
          end
        end
        SIZE: begin
          state  <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_move_long_sequencer.sv
// Scoreboard bench for move_long_sequencer: behavioural heap, copy model, arbitration log.
module tb_move_long_sequencer;
  localparam int W = 12, NA = 10, NR = 2, DEPTH = NA * NR;

  typedef struct packed {logic [W-1:0] a; logic [W-1:0] d;} wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  move_long_sequencer_if #(.MemoryElementWidth(W)) cmd_bus ();

  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [W-1:0] cpu_addr = '0, cpu_wdata = '0;
  logic         cpu_gnt, heap_en, heap_we, size_we;
  logic [W-1:0] heap_addr, heap_wdata, size_array, size_value;
  logic [W-1:0] heap_rdata = '0;

  move_long_sequencer #(.MemoryElementWidth(W), .NArea(NA), .NArrays(NR)) dut (
    .clock(clock), .reset(reset), .cmd(cmd_bus),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .heap_en(heap_en), .heap_we(heap_we), .heap_addr(heap_addr),
    .heap_wdata(heap_wdata), .heap_rdata(heap_rdata), .size_we(size_we),
    .size_array(size_array), .size_value(size_value)
  );

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] exp_mem [DEPTH];

  always @(posedge clock) begin
    if (heap_en) begin
      if (heap_we) begin
        if (heap_addr < W'(DEPTH)) mem[heap_addr[4:0]] <= heap_wdata;
      end else begin
        heap_rdata <= (heap_addr < W'(DEPTH)) ? mem[heap_addr[4:0]] : '0;
      end
    end
  end

  int  cyc = 0;
  int  acc_cyc = 0, done_cyc = 0, done_cnt = 0, err_cnt = 0, size_cnt = 0, eng_cnt = 0;
  bit  log_en = 1'b0;
  wr_t obs_wr[$], exp_wr[$], obs_size[$], exp_size[$];
  int  kind_q[$], exp_kind[$];
  int  n_cmp = 0, n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
        acc_cyc = cyc;
        kind_q.delete();
      end
      if (heap_en && !cpu_gnt) begin
        eng_cnt++;
        if (heap_we) obs_wr.push_back({heap_addr, heap_wdata});
      end
      if (size_we) begin
        size_cnt++;
        obs_size.push_back({size_array, size_value});
      end
      if (cmd_bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cmd_bus.error) err_cnt++;
      if (log_en) kind_q.push_back(cpu_gnt ? 1 : (heap_en ? (heap_we ? 3 : 2) : 0));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference copy: element-by-element so overlapping ascending moves smear.
  task automatic model_copy(input int sa, so, ta, to, len);
    bit down;
    exp_wr.delete(); exp_size.delete(); obs_wr.delete(); obs_size.delete();
`ifdef MOVE_LONG_OVERLAP_EN
    down = (sa == ta) && (so < to) && (to < so + len);
`else
    down = 1'b0;
`endif
    for (int i = 0; i < len; i++) begin
      int kk, s, t;
      kk = down ? len - 1 - i : i;
      s  = NA * sa + so + kk;
      t  = NA * ta + to + kk;
      exp_wr.push_back({W'(t), exp_mem[s]});
      exp_mem[t] = exp_mem[s];
    end
    if (len > 0) exp_size.push_back({W'(ta), W'(to + len)});
  endtask

  task automatic load_heap();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clock); #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = W'(i);
      cpu_wdata = (i < NA) ? W'(i) : W'(100 + i - NA);
      exp_mem[i] = cpu_wdata;
    end
    @(posedge clock); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic issue(input int sa, so, ta, to, len);
    int guard = 0;
    @(posedge clock); #1;
    while (!cmd_bus.cmd_ready) begin
      @(posedge clock); #1;
      if (++guard > 60) begin
        $display("FAIL issue_timeout: cmd_ready=%0b required 1", cmd_bus.cmd_ready);
        $fatal(1, "cmd_ready never rose");
      end
    end
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_source_array = W'(sa); cmd_bus.cmd_source_offset = W'(so);
    cmd_bus.cmd_target_array = W'(ta); cmd_bus.cmd_target_offset = W'(to);
    cmd_bus.cmd_length = W'(len);
    @(posedge clock); #1;
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clock); #1;
      if (done_cnt > n0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [57:0] outs;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = W'(5); cpu_wdata = W'(7);
    cmd_bus.cmd_valid = 1'b1;
    #12;
    outs = {cmd_bus.cmd_ready, cmd_bus.done, cmd_bus.error, cpu_gnt, heap_en, heap_we,
            heap_addr, heap_wdata, size_we, size_array, size_value};
    n_cmp++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", outs);
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cmd_bus.cmd_valid = 1'b0;
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %0b required 1", cmd_bus.cmd_ready);
    end
  endtask

  task automatic test_cpu_passthrough();
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = W'(19); cpu_wdata = W'(123);
    exp_mem[19] = W'(123);
    @(negedge clock); #1;
    n_cmp++;
    if ({cpu_gnt, heap_en, heap_we, heap_addr, heap_wdata} !== {3'b111, W'(19), W'(123)}) begin
      n_fail++;
      $display("FAIL cpu_pass: got gnt=%0b en=%0b we=%0b addr=%0d wdata=%0d required 1 1 1 19 123",
               cpu_gnt, heap_en, heap_we, heap_addr, heap_wdata);
    end
    @(posedge clock); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    n_cmp++;
    if (mem[19] !== W'(123)) begin
      n_fail++; $display("FAIL cpu_write: got %0d required 123", mem[19]);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int d0 = done_cnt;
    load_heap();
    model_copy(0, 4, 1, 2, 3);
    issue(0, 4, 1, 2, 3);
    wait_done(d0, ok);
    n_cmp++;
    if (!ok || done_cyc - acc_cyc != 8) begin
      n_fail++; $display("FAIL basic_latency: got ok=%0b cycles=%0d required 8", ok, done_cyc - acc_cyc);
    end
    @(negedge clock); #1;
    n_cmp++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready_after: got %0b required 1", cmd_bus.cmd_ready);
    end
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL basic_write: got %0d<-%0d required %0d<-%0d", o.a, o.d, e.a, e.d);
      end
    end
    n_cmp++;
    if (obs_size.size() != 1 || obs_size[0] !== exp_size[0]) begin
      n_fail++; $display("FAIL basic_size: got %0d entries first=%h required 1 entry %h",
                         obs_size.size(), (obs_size.size() > 0) ? obs_size[0] : '0, exp_size[0]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL basic_heap[%0d]: got %0d required %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    bit ok;
    int d0 = done_cnt, e0 = eng_cnt, s0 = size_cnt;
    issue(1, 3, 0, 5, 0);
    wait_done(d0, ok);
    n_cmp++;
    if (!ok || done_cyc - acc_cyc != 1) begin
      n_fail++; $display("FAIL len0_latency: got ok=%0b cycles=%0d required 1", ok, done_cyc - acc_cyc);
    end
    n_cmp++;
    if (eng_cnt != e0 || size_cnt != s0) begin
      n_fail++; $display("FAIL len0_access: got heap=%0d size=%0d required 0 0", eng_cnt - e0, size_cnt - s0);
    end
  endtask

  task automatic test_error();
    int cases [2][5] = '{'{0, 8, 1, 0, 3}, '{2, 0, 0, 0, 1}};
    int d0 = done_cnt, e0 = eng_cnt;
    for (int c = 0; c < 2; c++) begin
      issue(cases[c][0], cases[c][1], cases[c][2], cases[c][3], cases[c][4]);
      @(negedge clock); #1;
      n_cmp++;
      if ({cmd_bus.error, cmd_bus.cmd_ready} !== 2'b10) begin
        n_fail++; $display("FAIL error_pulse%0d: got error=%0b ready=%0b required 1 0",
                           c, cmd_bus.error, cmd_bus.cmd_ready);
      end
      @(negedge clock); #1;
      n_cmp++;
      if ({cmd_bus.error, cmd_bus.cmd_ready} !== 2'b01) begin
        n_fail++; $display("FAIL error_recover%0d: got error=%0b ready=%0b required 0 1",
                           c, cmd_bus.error, cmd_bus.cmd_ready);
      end
    end
    n_cmp++;
    if (eng_cnt != e0 || done_cnt != d0) begin
      n_fail++; $display("FAIL error_side_effects: got heap=%0d done=%0d required 0 0",
                         eng_cnt - e0, done_cnt - d0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL error_heap[%0d]: got %0d required %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    int d0 = done_cnt;
    int pattern [9] = '{1, 1, 2, 3, 1, 2, 3, 1, 1};
    load_heap();
    model_copy(0, 0, 1, 7, 2);
    exp_kind.delete();
    foreach (pattern[i]) exp_kind.push_back(pattern[i]);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = W'(19);
    log_en = 1'b1;
    issue(0, 0, 1, 7, 2);
    wait_done(d0, ok);
    log_en = 1'b0;
    cpu_req = 1'b0;
    n_cmp++;
    if (!ok || done_cyc - acc_cyc != 8) begin
      n_fail++; $display("FAIL contend_latency: got ok=%0b cycles=%0d required 8", ok, done_cyc - acc_cyc);
    end
    for (int i = 0; exp_kind.size() > 0; i++) begin
      int e = exp_kind.pop_front();
      int o = (kind_q.size() > 0) ? kind_q.pop_front() : -1;
      n_cmp++;
      if (o != e) begin
        n_fail++; $display("FAIL contend_slot%0d: got owner %0d required %0d", i, o, e);
      end
    end
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL contend_write: got %0d<-%0d required %0d<-%0d", o.a, o.d, e.a, e.d);
      end
    end
  endtask

  task automatic test_overlap();
    bit ok;
    int d0 = done_cnt;
    load_heap();
    model_copy(0, 0, 0, 1, 4);
    issue(0, 0, 0, 1, 4);
    wait_done(d0, ok);
    n_cmp++;
    if (!ok || done_cyc - acc_cyc != 10) begin
      n_fail++; $display("FAIL overlap_latency: got ok=%0b cycles=%0d required 10", ok, done_cyc - acc_cyc);
    end
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_cmp++;
      if (o !== e) begin
        n_fail++; $display("FAIL overlap_write: got %0d<-%0d required %0d<-%0d", o.a, o.d, e.a, e.d);
      end
    end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if (mem[i] !== exp_mem[i]) begin
        n_fail++; $display("FAIL overlap_heap[%0d]: got %0d required %0d", i, mem[i], exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [57:0] outs;
    int d0, s0;
    load_heap();
    d0 = done_cnt; s0 = size_cnt;
    issue(0, 4, 1, 2, 3);
    repeat (4) @(negedge clock);
    #1;
    reset = 1'b0; cpu_req = 1'b1;
    #1;
    outs = {cmd_bus.cmd_ready, cmd_bus.done, cmd_bus.error, cpu_gnt, heap_en, heap_we,
            heap_addr, heap_wdata, size_we, size_array, size_value};
    n_cmp++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h required 0", outs);
    end
    repeat (3) @(posedge clock);
    #1;
    cpu_req = 1'b0; reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++;
    if (done_cnt != d0 || size_cnt != s0) begin
      n_fail++; $display("FAIL midreset_pulses: got done=%0d size=%0d required 0 0", done_cnt - d0, size_cnt - s0);
    end
    n_cmp++;
    if ({mem[12], mem[13], mem[14]} !== {W'(4), W'(103), W'(104)}) begin
      n_fail++; $display("FAIL midreset_heap: got %0d %0d %0d required 4 103 104", mem[12], mem[13], mem[14]);
    end
    n_cmp++;
    if (cmd_bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_ready: got %0b required 1", cmd_bus.cmd_ready);
    end
  endtask

  initial begin
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_source_array = '0; cmd_bus.cmd_source_offset = '0;
    cmd_bus.cmd_target_array = '0; cmd_bus.cmd_target_offset = '0;
    cmd_bus.cmd_length = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    test_reset();
    load_heap();
    test_cpu_passthrough();
    test_basic();
    test_len_zero();
    test_error();
    test_contention();
    test_overlap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/move_long_sequencer.md
MOVE_LONG_SEQUENCER -- requirements
Module: move_long_sequencer

Interface
REQ-001 SHALL provide parameter MemoryElementWidth, default 12, heap element and command field width.
REQ-002 SHALL provide parameter NArea, default 10, elements per array area on the heap.
REQ-003 SHALL provide parameter NArrays, default 2, number of array areas; heap depth = NArea*NArrays.
REQ-004 SHALL have port clock input 1, sole clock, all state on its rising edge.
REQ-005 SHALL have port reset input 1, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid input 1 and cmd_ready output 1: command handshake, transfer when both high on a clock edge.
REQ-007 SHALL have ports cmd_source_array, cmd_source_offset, cmd_target_array, cmd_target_offset, cmd_length, each input MemoryElementWidth: moveLong operands.
REQ-008 SHALL have ports done output 1 and error output 1: one-cycle completion and rejection pulses.
REQ-009 SHALL have ports cpu_req input 1, cpu_we input 1, cpu_addr input MemoryElementWidth, cpu_wdata input MemoryElementWidth and cpu_gnt output 1: shared-heap requester port.
REQ-010 SHALL have ports heap_en output 1, heap_we output 1, heap_addr output MemoryElementWidth, heap_wdata output MemoryElementWidth and heap_rdata input MemoryElementWidth: single heap port with 1-cycle read latency.
REQ-011 SHALL have ports size_we output 1, size_array output MemoryElementWidth and size_value output MemoryElementWidth: array length update; the consumer stores max(current, size_value).

Function
REQ-012 SHALL use FSM states IDLE, READ, WRITE, SIZE and DONE; cmd_ready SHALL be high only in IDLE.
REQ-013 SHALL, in IDLE on handshake, latch all operands and go to READ with element index k=0; cmd_valid outside IDLE SHALL be ignored.
REQ-014 SHALL, on accept, pulse error (next cycle), perform no heap access and return to IDLE if either array >= NArrays, source_offset+length > NArea or target_offset+length > NArea.
REQ-015 SHALL, on accept with length 0 and legal operands, go directly to DONE with no heap access and no size_we.
REQ-016 SHALL, in READ, drive heap_en=1, heap_we=0, heap_addr = NArea*source_array + source_offset + k, and go to WRITE.
REQ-017 SHALL, in WRITE, drive heap_en=1, heap_we=1, heap_addr = NArea*target_array + target_offset + k, heap_wdata = heap_rdata, then increment k; it SHALL go to READ if k < length, else to SIZE.
REQ-018 SHALL, in SIZE, pulse size_we with size_array = target_array and size_value = target_offset + length, then go to DONE.
REQ-019 SHALL, in DONE, pulse done for one cycle and return to IDLE.
REQ-020 SHALL, uncontended, complete with the first READ 1 cycle after accept, the last WRITE at cycle 2*length, size_we at 2*length+1, done at 2*length+2 and cmd_ready high at 2*length+3.
REQ-021 SHALL arbitrate the heap port as follows: IDLE, SIZE and DONE grant the CPU whenever cpu_req; WRITE never grants the CPU.
REQ-022 SHALL, in READ with cpu_req high, grant the CPU if the engine won the previous contested READ slot, else the engine; the CPU SHALL win the first contest after accept; the loser stalls one cycle.
REQ-023 SHALL pass cpu_we/cpu_addr/cpu_wdata to the heap port combinationally in any cycle cpu_gnt=1.
REQ-024 SHALL compute all addresses modulo 2^MemoryElementWidth and all arithmetic unsigned.

Reset
REQ-025 SHALL, when reset is low, force FSM to IDLE, k=0 and arbitration history to "engine won last", asynchronously.
REQ-026 SHALL, during reset, hold cmd_ready=0, done=0, error=0, cpu_gnt=0, heap_en=0, heap_we=0, size_we=0, and heap_addr, heap_wdata, size_array, size_value = 0.
REQ-027 SHALL, on reset mid-copy, abandon the command without done or size_we; already-written elements remain.

Configuration
REQ-028 SHALL, with MOVE_LONG_OVERLAP_EN defined, copy descending (k from length-1 down to 0) when source_array == target_array and source_offset < target_offset < source_offset+length, otherwise ascending.
REQ-029 SHALL, without MOVE_LONG_OVERLAP_EN, always copy ascending; latency is identical in both builds.

Verification
REQ-030 SHALL check this case: heap array0 = 0..9, array1 = 100..109; command src 0/4, tgt 1/2, len 3 -> heap[12..14] = 4,5,6; size_we with 1/5; done 8 cycles after accept.
REQ-031 SHALL check this case: length 0 -> no heap_en from the engine; done 1 cycle after accept; no size_we.
REQ-032 SHALL check this case: src 0/8, len 3 (NArea 10) -> error pulse; heap unchanged; cmd_ready high again in 2 cycles.
REQ-033 SHALL check this case: cpu_req held high during len 2 copy -> grants alternate CPU/engine in READ slots; CPU never granted in WRITE; done delayed by exactly 2 cycles.
REQ-034 SHALL check this case: with MOVE_LONG_OVERLAP_EN, array0 = 0..9, src 0/0, tgt 0/1, len 4 -> heap[1..4] = 0,1,2,3; without the macro -> 0,0,0,0.
REQ-035 SHALL check this case: reset asserted at the second WRITE of len 3 -> outputs 0 immediately; heap[12] written, heap[13..14] untouched; no done.
